// File: rtl/video_pkg.sv
// Shared types and constants for the test pattern generator.
// Pixel format is RGB565 packed as {r, g, b}, MSB first.
package video_pkg;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  typedef enum logic [1:0] {
    PAT_BARS  = 2'd0,
    PAT_CHECK = 2'd1,
    PAT_RAMP  = 2'd2,
    PAT_SOLID = 2'd3
  } pattern_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } tpg_state_e;

  localparam rgb565_t BAR_WHITE   = 16'hFFFF;
  localparam rgb565_t BAR_YELLOW  = 16'hFFE0;
  localparam rgb565_t BAR_CYAN    = 16'h07FF;
  localparam rgb565_t BAR_GREEN   = 16'h07E0;
  localparam rgb565_t BAR_MAGENTA = 16'hF81F;
  localparam rgb565_t BAR_RED     = 16'hF800;
  localparam rgb565_t BAR_BLUE    = 16'h001F;
  localparam rgb565_t BAR_BLACK   = 16'h0000;

endpackage

// File: rtl/video_tpg_pattern.sv
// Combinational pixel colour for one raster coordinate; zero latency.
// No flow control: the caller registers the result when it loads a pixel.
import video_pkg::*;

module video_tpg_pattern #(
  parameter int CHECK_LOG2 = 5
) (
  input  logic [11:0] x,
  input  logic [11:0] y,
  input  logic [2:0]  bar_idx,
  input  pattern_e    pattern,
  input  rgb565_t     solid_rgb,
  output rgb565_t     pixel
);

  // Only a few coordinate bits feed the colour maps.
  logic unused_coords;
  assign unused_coords = ^{x, y};

  always_comb begin
    pixel = '0;
    unique case (pattern)
      PAT_BARS: begin
        case (bar_idx)
          3'd0: pixel = BAR_WHITE;
          3'd1: pixel = BAR_YELLOW;
          3'd2: pixel = BAR_CYAN;
          3'd3: pixel = BAR_GREEN;
          3'd4: pixel = BAR_MAGENTA;
          3'd5: pixel = BAR_RED;
          3'd6: pixel = BAR_BLUE;
          3'd7: pixel = BAR_BLACK;
        endcase
      end
      PAT_CHECK: pixel = (x[CHECK_LOG2] ^ y[CHECK_LOG2]) ? BAR_BLACK : BAR_WHITE;
      PAT_RAMP:  pixel = '{r: x[5:1], g: x[5:0], b: x[5:1]};
      PAT_SOLID: pixel = solid_rgb;
    endcase
  end

endmodule

// File: rtl/video_tpg_source.sv
// Avalon-ST raster test pattern source; first pixel one edge after enable in IDLE.
// Output register holds data/sop/eop while st_ready is low; frames never truncate.
import video_pkg::*;

module video_tpg_source #(
  parameter int XRES       = 640,
  parameter int YRES       = 480,
  parameter int CHECK_LOG2 = 5
) (
  input  logic        clock,
  input  logic        areset,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  input  logic [15:0] solid_rgb,
  input  logic        st_ready,
  output logic        st_valid,
  output logic [15:0] st_data,
  output logic        st_sop,
  output logic        st_eop,
  output logic [7:0]  frame_count
);

  localparam logic [11:0] XMAX = 12'(XRES - 1);
  localparam logic [11:0] YMAX = 12'(YRES - 1);
  localparam logic [11:0] BMAX = 12'(XRES / 8 - 1);

  tpg_state_e  state_q, state_d;
  logic [11:0] cx_q, cy_q, bcnt_q;
  logic [2:0]  bidx_q;
  pattern_e    pat_q;
  rgb565_t     solid_q;

  logic        xfer, load_sop, load_next;
  logic [11:0] nx, ny, nbcnt;
  logic [2:0]  nbidx;
  pattern_e    pat_mux;
  rgb565_t     solid_mux, pix;

  assign xfer = st_valid & st_ready;

  always_comb begin
    state_d   = state_q;
    load_sop  = 1'b0;
    load_next = 1'b0;
    nx        = cx_q;
    ny        = cy_q;
    nbcnt     = bcnt_q;
    nbidx     = bidx_q;

    case (state_q)
      IDLE: begin
        if (enable) begin
          load_sop = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (xfer) begin
          if (st_eop) begin
            if (enable) load_sop = 1'b1;
            else        state_d  = IDLE;
          end else begin
            load_next = 1'b1;
          end
        end
      end
    endcase

    // Coordinates of the pixel about to be loaded; bar index advances without a divider.
    if (load_sop) begin
      nx    = '0;
      ny    = '0;
      nbcnt = '0;
      nbidx = '0;
    end else if (cx_q == XMAX) begin
      nx    = '0;
      ny    = cy_q + 12'd1;
      nbcnt = '0;
      nbidx = '0;
    end else begin
      nx = cx_q + 12'd1;
      if (bcnt_q == BMAX) begin
        nbcnt = '0;
        nbidx = bidx_q + 3'd1;
      end else begin
        nbcnt = bcnt_q + 12'd1;
      end
    end

    // The sop pixel already uses the freshly sampled pattern selection.
    pat_mux   = load_sop ? pattern_e'(pattern_sel) : pat_q;
    solid_mux = load_sop ? rgb565_t'(solid_rgb) : solid_q;
  end

  video_tpg_pattern #(
    .CHECK_LOG2 (CHECK_LOG2)
  ) u_pattern (
    .x         (nx),
    .y         (ny),
    .bar_idx   (nbidx),
    .pattern   (pat_mux),
    .solid_rgb (solid_mux),
    .pixel     (pix)
  );

  always_ff @(posedge clock or posedge areset) begin
    if (areset) begin
      state_q     <= IDLE;
      cx_q        <= '0;
      cy_q        <= '0;
      bcnt_q      <= '0;
      bidx_q      <= '0;
      pat_q       <= PAT_BARS;
      solid_q     <= '0;
      st_valid    <= 1'b0;
      st_data     <= '0;
      st_sop      <= 1'b0;
      st_eop      <= 1'b0;
      frame_count <= '0;
    end else begin
      state_q <= state_d;
      if (xfer && st_eop) frame_count <= frame_count + 8'd1;
      if (load_sop || load_next) begin
        cx_q     <= nx;
        cy_q     <= ny;
        bcnt_q   <= nbcnt;
        bidx_q   <= nbidx;
        st_valid <= 1'b1;
        st_data  <= pix;
        st_sop   <= load_sop;
        st_eop   <= (nx == XMAX) && (ny == YMAX);
      end else if (xfer) begin
        st_valid <= 1'b0;
      end
      if (load_sop) begin
        pat_q   <= pat_mux;
        solid_q <= solid_mux;
      end
    end
  end

endmodule

// File: tb/tb_video_tpg_source.sv
// Directed bench for video_tpg_source at 16x4 pixels, checker squares of 2.
module tb_video_tpg_source;

  localparam int XR   = 16;
  localparam int YR   = 4;
  localparam int NPIX = XR * YR;

  logic        clock = 1'b0;
  logic        areset;
  logic        enable;
  logic [1:0]  pattern_sel;
  logic [15:0] solid_rgb;
  logic        st_ready;
  logic        st_valid;
  logic [15:0] st_data;
  logic        st_sop;
  logic        st_eop;
  logic [7:0]  frame_count;

  int n_run  = 0;
  int n_fail = 0;

  logic [15:0] fdat [NPIX];
  logic        fsop [NPIX];
  logic        feop [NPIX];
  logic [15:0] ref_dat [NPIX];
  logic [15:0] last_d;
  logic        last_s, last_e;

  video_tpg_source #(
    .XRES       (XR),
    .YRES       (YR),
    .CHECK_LOG2 (1)
  ) dut (
    .clock       (clock),
    .areset      (areset),
    .enable      (enable),
    .pattern_sel (pattern_sel),
    .solid_rgb   (solid_rgb),
    .st_ready    (st_ready),
    .st_valid    (st_valid),
    .st_data     (st_data),
    .st_sop      (st_sop),
    .st_eop      (st_eop),
    .frame_count (frame_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref_pix(input int x, input int y, input logic [1:0] p,
                                          input logic [15:0] s);
    logic [5:0] xs;
    xs = x[5:0];
    case (p)
      2'd0: begin
        case (x / (XR / 8))
          0: return 16'hFFFF;
          1: return 16'hFFE0;
          2: return 16'h07FF;
          3: return 16'h07E0;
          4: return 16'hF81F;
          5: return 16'hF800;
          6: return 16'h001F;
          default: return 16'h0000;
        endcase
      end
      2'd1: return ((((x >> 1) ^ (y >> 1)) & 1) != 0) ? 16'h0000 : 16'hFFFF;
      2'd2: return {xs[5:1], xs, xs[5:1]};
      default: return s;
    endcase
  endfunction

  // One clock; reports whether a beat was accepted and checks the hold rule on stalls.
  task automatic cycle(input logic rdy, output logic got);
    logic pv, ps, pe;
    logic [15:0] pd;
    st_ready = rdy;
    pv = st_valid; pd = st_data; ps = st_sop; pe = st_eop;
    @(posedge clock);
    #1;
    got = pv & rdy;
    if (got) begin
      last_d = pd; last_s = ps; last_e = pe;
    end else if (pv) begin
      check("stall_hold", {13'd0, st_valid, st_sop, st_eop, st_data}, {13'd0, 1'b1, ps, pe, pd});
    end
  endtask

  task automatic recv_frame(input int pct, input int chg_beat, input logic [1:0] np,
                            input logic [15:0] ns, input logic ne);
    int n, cyc;
    logic got, rdy;
    n = 0;
    cyc = 0;
    while (n < NPIX && cyc < 4000) begin
      rdy = (pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < pct);
      cycle(rdy, got);
      cyc++;
      if (got) begin
        fdat[n] = last_d; fsop[n] = last_s; feop[n] = last_e;
        n++;
        if (n == chg_beat) begin
          pattern_sel = np; solid_rgb = ns; enable = ne;
        end
      end
    end
    check("frame_beats", n, NPIX);
  endtask

  task automatic verify(input string tag, input logic [1:0] p, input logic [15:0] s);
    int errs;
    errs = 0;
    for (int i = 0; i < NPIX; i++) begin
      if (fdat[i] !== ref_pix(i % XR, i / XR, p, s)) errs++;
      if (fsop[i] !== (i == 0)) errs++;
      if (feop[i] !== (i == NPIX - 1)) errs++;
    end
    check({tag, "_frame"}, errs, 0);
  endtask

  initial begin
    int cnt, errs;
    logic got;
    areset = 1'b1; enable = 1'b0; pattern_sel = 2'd0; solid_rgb = 16'h0; st_ready = 1'b0;
    #12;
    check("rst_valid", st_valid, 0);
    check("rst_data", st_data, 0);
    check("rst_sopeop", {st_sop, st_eop}, 0);
    check("rst_fc", frame_count, 0);
    areset = 1'b0;

    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      cycle(1'b1, got);
      if (st_valid) cnt++;
    end
    check("idle_no_valid", cnt, 0);

    // Frame 1: bars, no stalls, first pixel one edge after enable
    enable = 1'b1;
    st_ready = 1'b0;
    @(posedge clock); #1;
    check("lat_valid", st_valid, 1);
    check("lat_sop", st_sop, 1);
    recv_frame(100, -1, 2'd0, 16'h0, 1'b1);
    verify("bars1", 2'd0, 16'h0);
    check("bar_b0", fdat[0], 16'hFFFF);
    check("bar_b0_sop", fsop[0], 1);
    check("bar_b2", fdat[2], 16'hFFE0);
    check("bar_b3", fdat[3], 16'hFFE0);
    check("bar_b15", fdat[15], 16'h0000);
    check("bar_b63_eop", feop[63], 1);
    check("nobubble_valid", st_valid, 1);
    check("nobubble_sop", st_sop, 1);
    check("fc1", frame_count, 1);
    for (int i = 0; i < NPIX; i++) ref_dat[i] = fdat[i];

    // Frame 2: 50% backpressure must not change the pixel stream
    recv_frame(50, -1, 2'd0, 16'h0, 1'b1);
    errs = 0;
    for (int i = 0; i < NPIX; i++) if (fdat[i] !== ref_dat[i]) errs++;
    check("bp_vs_nostall", errs, 0);
    verify("bp", 2'd0, 16'h0);
    check("fc2", frame_count, 2);

    // Frame 3: switch to solid mid-frame; this frame stays bars
    recv_frame(100, 10, 2'd3, 16'h1234, 1'b1);
    verify("switch_bars", 2'd0, 16'h0);

    // Frame 4: solid, then request checker for the next frame
    recv_frame(100, 5, 2'd1, 16'h1234, 1'b1);
    verify("solid", 2'd3, 16'h1234);
    check("solid_b0", fdat[0], 16'h1234);
    check("solid_b40", fdat[40], 16'h1234);

    // Frame 5: checker, then request ramp
    recv_frame(100, 5, 2'd2, 16'h1234, 1'b1);
    verify("check", 2'd1, 16'h0);
    check("chk_b0", fdat[0], 16'hFFFF);
    check("chk_b2", fdat[2], 16'h0000);
    check("chk_b32", fdat[32], 16'h0000);
    check("chk_b34", fdat[34], 16'hFFFF);

    // Frame 6: ramp; enable drops at beat 20 but the frame completes
    recv_frame(100, 20, 2'd0, 16'h1234, 1'b0);
    verify("ramp", 2'd2, 16'h0);
    check("ramp_b5", fdat[5], 16'h10A2);
    check("ramp_b15", fdat[15], 16'h39E7);
    check("stop_eop63", feop[63], 1);
    check("stop_valid", st_valid, 0);
    check("stop_fc", frame_count, 6);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, got);
      if (st_valid) cnt++;
    end
    check("stop_idle", cnt, 0);

    // Reset in the middle of a frame
    enable = 1'b1;
    cnt = 0;
    for (int i = 0; i < 200 && cnt < 30; i++) begin
      cycle(1'b1, got);
      if (got) cnt++;
    end
    check("pre_rst_beats", cnt, 30);
    #2 areset = 1'b1;
    #1;
    check("midrst_valid", st_valid, 0);
    check("midrst_fc", frame_count, 0);
    check("midrst_data", st_data, 0);
    #3 areset = 1'b0;
    st_ready = 1'b0;
    @(posedge clock); #1;
    check("after_rst_valid", st_valid, 1);
    check("after_rst_sop", st_sop, 1);
    check("after_rst_data", st_data, 16'hFFFF);
    recv_frame(100, -1, 2'd0, 16'h0, 1'b1);
    verify("after_rst", 2'd0, 16'h0);
    check("after_rst_fc", frame_count, 1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/video_tpg_source.md
Name: video_tpg_source

Overview:
- Test pattern generator; the Avalon-ST video source feeding the VGA output stage in the system clock domain.
- Emits raster-ordered RGB565 pixel frames with start/end-of-packet framing and ready/valid backpressure.
- Selectable patterns (colour bars, checkerboard, grey ramp, solid colour) bring up and verify the display path without a frame buffer.

Parameters:
- XRES, 640: active pixels per line; must be a multiple of 8, max 4095.
- YRES, 480: active lines per frame; max 4095.
- CHECK_LOG2, 5: log2 of checkerboard square size in pixels (1..10).

Ports:
- clock  in  1  system clock.
- areset  in  1  asynchronous active-high reset.
- enable  in  1  run request; frames start only while high.
- pattern_sel  in  2  0 bars, 1 checker, 2 ramp, 3 solid.
- solid_rgb  in  16  RGB565 colour for pattern 3.
- st_ready  in  1  sink ready.
- st_valid  out  1  pixel valid.
- st_data  out  16  RGB565 pixel: R[15:11], G[10:5], B[4:0].
- st_sop  out  1  first pixel of frame (x=0, y=0).
- st_eop  out  1  last pixel of frame (x=XRES-1, y=YRES-1).
- frame_count  out  8  completed frames, wraps 255->0.

Behaviour:
- Reset (async assert, sync release): st_valid=0, st_data=0, st_sop=0, st_eop=0, frame_count=0, x=y=0, state IDLE.
- Output register: a transfer occurs on a clock edge with st_valid & st_ready.
  - While st_valid & !st_ready, st_data/st_sop/st_eop hold unchanged.
  - st_valid never drops without a transfer.
- Per-frame pattern register: pattern_sel and solid_rgb are sampled only when the sop pixel is loaded. Mid-frame changes take effect on the next frame.
- State machine:
  - IDLE: if enable=1, load pixel (0,0) with sop=1 on the next edge, st_valid=1, go to RUN.
  - RUN: on each transfer, load the next pixel. x increments; at XRES-1, x wraps to 0 and y increments.
  - On transfer of the eop pixel: frame_count++.
    - If enable=1, load (0,0) with sop on the same edge (no bubble).
    - Else st_valid=0, go to IDLE.
  - enable falling mid-frame never truncates a frame; the current frame completes.
- Pixel count per frame is exactly XRES*YRES; sop and eop occur exactly once each.
- If XRES*YRES=1, sop and eop are asserted on the same beat.
- Latency: first valid pixel one edge after enable is sampled high in IDLE.
- Pattern functions (x, y = coordinates of the pixel being loaded):
  - Bars: 8 bars of XRES/8 pixels, derived from a bar counter and bar index (no divider). Order and values:
    - white 0xFFFF, yellow 0xFFE0, cyan 0x07FF, green 0x07E0
    - magenta 0xF81F, red 0xF800, blue 0x001F, black 0x0000
  - Checker: x[CHECK_LOG2] ^ y[CHECK_LOG2]; 0 gives white 0xFFFF, 1 gives black 0x0000.
  - Ramp: grey repeating every 64 pixels; R=x[5:1], G=x[5:0], B=x[5:1].
  - Solid: sampled solid_rgb.
- Reset mid-frame: outputs go to reset values immediately. The next frame after release starts at (0,0) with sop.

Decomposition:
- Shared package video_pkg:
  - rgb565_t struct (r 5, g 6, b 5).
  - pattern_e enum (PAT_BARS, PAT_CHECK, PAT_RAMP, PAT_SOLID).
  - The eight bar colour constants.
  - tpg_state_e (IDLE, RUN).
- One sub-module, video_tpg_pattern: purely combinational map from (x, y, bar index, pattern, solid_rgb) to rgb565_t.
- Counters, FSM and output register live in the top.

Test Plan:
- Bench parameters: XRES=16, YRES=4, CHECK_LOG2=1.
- Reset/idle: areset pulse with enable=0 -> all outputs 0, no st_valid for 100 cycles.
- Bars, st_ready=1: enable=1 -> 64 beats per frame; beat 0 0xFFFF with sop; beats 2,3 0xFFE0; beat 15 0x0000; beat 63 eop; frame 2 sop follows on the very next cycle with no bubble.
- Backpressure: random st_ready at 50% -> st_data/st_sop/st_eop stable while stalled; scoreboard pixel sequence identical to the no-stall case.
- Pattern switch: pattern_sel 0->3 with solid_rgb=0x1234 mid-frame -> rest of frame still bars; next frame all 0x1234.
- Stop: enable low at beat 20 -> frame ends at beat 63 with eop, st_valid=0 afterwards, frame_count incremented by 1.
- Reset mid-frame: areset at beat 30 -> st_valid=0 asynchronously; after release, first beat is (0,0) 0xFFFF with sop; frame_count=0.
